// File: rtl/writeback_unit.sv
// Register-file write-side master: registers ALU results, waits for and aligns load data, pulses rwe.
// Optional operand forwarding from the write port is enabled with `define WB_BYPASS_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a new instruction; ALU results are written from here
// LOAD_WAIT | load accepted, waiting for mem_rsp_valid or timeout
// LOAD_DONE | cycle of the load write pulse; upstream still stalled
module writeback_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:4]  in_rd,
    input  logic [0:31] in_result,
    input  logic        in_load,
    input  logic [0:1]  in_ldsize,
    input  logic        in_ldsigned,
    input  logic        mem_rsp_valid,
    input  logic [0:31] mem_rsp_data,
    output logic [0:4]  rdOut,
    output logic [0:31] writeBackData,
    output logic        rwe,
    output logic        err
`ifdef WB_BYPASS_EN
    ,
    input  logic [0:4]  rsIn,
    input  logic [0:4]  rtIn,
    output logic [0:31] rsFwd,
    output logic [0:31] rtFwd,
    output logic        rsFwdHit,
    output logic        rtFwdHit
`endif
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        LOAD_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [0:4]    ld_rd;
    logic [0:1]    ld_size;
    logic          ld_signed;
    logic [0:1]    ld_lane;
    logic          ld_bad;

    logic          bad_access;
    logic [0:7]    lane_byte;
    logic [0:15]   lane_half;
    logic [0:31]   load_ext;

    assign in_ready = (state == IDLE);

    // Reserved size or an address not aligned to the access size.
    assign bad_access = (in_ldsize == 2'b11)
                      | ((in_ldsize == 2'b01) & in_result[31])
                      | ((in_ldsize == 2'b10) & (in_result[30:31] != 2'b00));

    always_comb begin
        lane_byte = mem_rsp_data[0:7];
        case (ld_lane)
            2'b00:   lane_byte = mem_rsp_data[0:7];
            2'b01:   lane_byte = mem_rsp_data[8:15];
            2'b10:   lane_byte = mem_rsp_data[16:23];
            default: lane_byte = mem_rsp_data[24:31];
        endcase
        lane_half = ld_lane[0] ? mem_rsp_data[16:31] : mem_rsp_data[0:15];
        load_ext  = mem_rsp_data;
        case (ld_size)
            2'b00:   load_ext = {{24{ld_signed & lane_byte[0]}}, lane_byte};
            2'b01:   load_ext = {{16{ld_signed & lane_half[0]}}, lane_half};
            default: load_ext = mem_rsp_data;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            ld_rd         <= '0;
            ld_size       <= '0;
            ld_signed     <= 1'b0;
            ld_lane       <= '0;
            ld_bad        <= 1'b0;
            rdOut         <= '0;
            writeBackData <= '0;
            rwe           <= 1'b0;
            err           <= 1'b0;
        end else begin
            rwe <= 1'b0;
            // A response is only meaningful while a load is outstanding.
            if (mem_rsp_valid && (state != LOAD_WAIT))
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_load) begin
                            ld_rd     <= in_rd;
                            ld_size   <= in_ldsize;
                            ld_signed <= in_ldsigned;
                            ld_lane   <= in_result[30:31];
                            ld_bad    <= bad_access;
                            cnt       <= '0;
                            state     <= LOAD_WAIT;
                            if (bad_access)
                                err <= 1'b1;
                        end else if (in_rd != 5'd0) begin
                            rdOut         <= in_rd;
                            writeBackData <= in_result;
                            rwe           <= 1'b1;
                        end
                    end
                end
                LOAD_WAIT: begin
                    if (mem_rsp_valid) begin
                        state <= LOAD_DONE;
                        if (!ld_bad && (ld_rd != 5'd0)) begin
                            rdOut         <= ld_rd;
                            writeBackData <= load_ext;
                            rwe           <= 1'b1;
                        end
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                LOAD_DONE: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

`ifdef WB_BYPASS_EN
    assign rsFwdHit = rwe & (rdOut == rsIn) & (rsIn != 5'd0);
    assign rtFwdHit = rwe & (rdOut == rtIn) & (rtIn != 5'd0);
    assign rsFwd    = rsFwdHit ? writeBackData : 32'd0;
    assign rtFwd    = rtFwdHit ? writeBackData : 32'd0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed spec scenarios plus randomized ALU and load traffic.
module tb_writeback_unit;

    localparam int TO = 6;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic        in_load;
    logic [1:0]  in_ldsize;
    logic        in_ldsigned;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [4:0]  rdOut;
    logic [31:0] writeBackData;
    logic        rwe;
    logic        err;
`ifdef WB_BYPASS_EN
    logic [4:0]  rsIn, rtIn;
    logic [31:0] rsFwd, rtFwd;
    logic        rsFwdHit, rtFwdHit;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        exp_err;

    writeback_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_result(in_result),
        .in_load(in_load), .in_ldsize(in_ldsize), .in_ldsigned(in_ldsigned),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .rdOut(rdOut), .writeBackData(writeBackData), .rwe(rwe), .err(err)
`ifdef WB_BYPASS_EN
        , .rsIn(rsIn), .rtIn(rtIn), .rsFwd(rsFwd), .rtFwd(rtFwd),
        .rsFwdHit(rsFwdHit), .rtFwdHit(rtFwdHit)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Big-endian lane selection and extension written directly from the load rules.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        int bits;
        if (sz == 2'd0) begin
            v = (w >> (8 * (3 - int'(a)))) & 32'hFF;
            bits = 8;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * (1 - int'(a[1])))) & 32'hFFFF;
            bits = 16;
        end else begin
            v = w;
            bits = 32;
        end
        if (sg && bits < 32 && v[bits-1])
            v = v | ~((32'h1 << bits) - 32'h1);
        return v;
    endfunction

    task automatic clear_inputs;
        in_valid = 0; in_rd = 0; in_result = 0; in_load = 0; in_ldsize = 0;
        in_ldsigned = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
`ifdef WB_BYPASS_EN
        rsIn = 0; rtIn = 0;
`endif
    endtask

    task automatic do_reset;
        clear_inputs();
        reset_n = 0;
        step(); step();
        reset_n = 1;
        exp_rd = 0; exp_data = 0; exp_err = 0;
        step();
    endtask

    // Issues one load, waits dly response-free cycles, then supplies the response.
    task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [1:0] sz,
                           input logic sg, input logic [31:0] word, input int dly, input string tag);
        logic bad, we;
        int stall_bad;
        bad = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
        we  = !bad && (rd != 0);
        in_valid = 1; in_load = 1; in_rd = rd; in_result = addr; in_ldsize = sz; in_ldsigned = sg;
        step();
        in_valid = 0; in_load = 0;
        if (bad) exp_err = 1;
        n_cmp++; if (err !== exp_err) begin n_err++; $display("FAIL %s accept_err: got %b want %b", tag, err, exp_err); end
        stall_bad = 0;
        for (int i = 0; i < dly; i++) begin
            if (in_ready !== 1'b0 || rwe !== 1'b0) stall_bad++;
            step();
        end
        if (in_ready !== 1'b0 || rwe !== 1'b0) stall_bad++;
        n_cmp++; if (stall_bad != 0) begin n_err++; $display("FAIL %s wait: %0d bad cycles want 0", tag, stall_bad); end
        mem_rsp_valid = 1; mem_rsp_data = word;
        step();
        mem_rsp_valid = 0; mem_rsp_data = $urandom;
        if (we) begin exp_rd = rd; exp_data = ref_load(word, addr[1:0], sz, sg); end
        n_cmp++; if (rwe !== we) begin n_err++; $display("FAIL %s rwe: got %b want %b", tag, rwe, we); end
        n_cmp++; if (rdOut !== exp_rd || writeBackData !== exp_data)
            begin n_err++; $display("FAIL %s data: got %0d/%h want %0d/%h", tag, rdOut, writeBackData, exp_rd, exp_data); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL %s pulse_ready: got %b want 0", tag, in_ready); end
        step();
        n_cmp++; if (in_ready !== 1'b1 || rwe !== 1'b0 || err !== exp_err)
            begin n_err++; $display("FAIL %s after: ready/rwe/err got %b%b%b want 10%b", tag, in_ready, rwe, err, exp_err); end
    endtask

    task automatic test_reset;
        clear_inputs();
        reset_n = 0;
        #12;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        n_cmp++; if (rwe !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL reset_flags: rwe %b err %b want 0 0", rwe, err); end
        n_cmp++; if (rdOut !== 5'd0 || writeBackData !== 32'd0)
            begin n_err++; $display("FAIL reset_regs: got %0d/%h want 0/0", rdOut, writeBackData); end
        do_reset();
    endtask

    task automatic test_alu;
        in_valid = 1; in_load = 0; in_rd = 5'd2; in_result = 32'hDEED_DEED;
        step();
        in_rd = 5'd5; in_result = 32'hAAAA_DDDD;
        n_cmp++; if (rwe !== 1'b1 || rdOut !== 5'd2 || writeBackData !== 32'hDEED_DEED)
            begin n_err++; $display("FAIL alu_first: got %b %0d %h want 1 2 deeddeed", rwe, rdOut, writeBackData); end
        step();
        in_valid = 0;
        n_cmp++; if (rwe !== 1'b1 || rdOut !== 5'd5 || writeBackData !== 32'hAAAA_DDDD)
            begin n_err++; $display("FAIL alu_second: got %b %0d %h want 1 5 aaaadddd", rwe, rdOut, writeBackData); end
        step();
        n_cmp++; if (rwe !== 1'b0 || rdOut !== 5'd5 || writeBackData !== 32'hAAAA_DDDD)
            begin n_err++; $display("FAIL alu_hold: got %b %0d %h want 0 5 aaaadddd", rwe, rdOut, writeBackData); end
        exp_rd = 5'd5; exp_data = 32'hAAAA_DDDD;
    endtask

    task automatic test_alu_random;
        logic v, we;
        logic [4:0] rd;
        logic [31:0] res;
        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(0, 3) != 0);
            rd = 5'($urandom_range(0, 31));
            res = $urandom;
            in_valid = v; in_load = 0; in_rd = rd; in_result = res;
            step();
            we = v && (rd != 0);
            if (we) begin exp_rd = rd; exp_data = res; end
            n_cmp++; if (rwe !== we || rdOut !== exp_rd || writeBackData !== exp_data || in_ready !== 1'b1)
                begin n_err++; $display("FAIL alu_rand[%0d]: got %b %0d %h want %b %0d %h", i, rwe, rdOut, writeBackData, we, exp_rd, exp_data); end
        end
        in_valid = 0;
        n_cmp++; if (err !== exp_err) begin n_err++; $display("FAIL alu_rand_err: got %b want %b", err, exp_err); end
    endtask

    task automatic test_loads;
        logic [1:0] sz;
        logic [31:0] addr;
        do_load(5'd3, 32'h0000_1001, 2'd0, 1'b1, 32'h12F4_5678, 1, "lb_signed");
        n_cmp++; if (writeBackData !== 32'hFFFF_FFF4) begin n_err++; $display("FAIL lb_value: got %h want fffffff4", writeBackData); end
        do_load(5'd4, 32'h0000_2002, 2'd1, 1'b0, 32'h1234_8001, 0, "lhu");
        n_cmp++; if (writeBackData !== 32'h0000_8001) begin n_err++; $display("FAIL lhu_value: got %h want 00008001", writeBackData); end
        for (int i = 0; i < 24; i++) begin
            sz = 2'($urandom_range(0, 2));
            addr = $urandom;
            if (sz == 2'd1) addr[0] = 1'b0;
            if (sz == 2'd2) addr[1:0] = 2'b00;
            do_load(5'($urandom_range(1, 31)), addr, sz, 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(0, TO - 1), "load_rand");
        end
    endtask

    task automatic test_stall;
        logic [31:0] w;
        int lows;
        w = $urandom;
        in_valid = 1; in_load = 1; in_rd = 5'd3; in_result = 32'h100; in_ldsize = 2'd2; in_ldsigned = 0;
        step();
        in_load = 0; in_rd = 5'd9; in_result = 32'hC0FF_EE00;
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            if (in_ready === 1'b0 && rwe === 1'b0) lows++;
            step();
        end
        mem_rsp_valid = 1; mem_rsp_data = w;
        if (in_ready === 1'b0) lows++;
        step();
        mem_rsp_valid = 0;
        if (in_ready === 1'b0) lows++;
        n_cmp++; if (lows != 7) begin n_err++; $display("FAIL stall_low: got %0d cycles want 7", lows); end
        n_cmp++; if (rwe !== 1'b1 || rdOut !== 5'd3 || writeBackData !== w)
            begin n_err++; $display("FAIL stall_pulse: got %b %0d %h want 1 3 %h", rwe, rdOut, writeBackData, w); end
        step();
        n_cmp++; if (in_ready !== 1'b1 || rwe !== 1'b0) begin n_err++; $display("FAIL stall_release: ready %b rwe %b want 1 0", in_ready, rwe); end
        step();
        in_valid = 0;
        n_cmp++; if (rwe !== 1'b1 || rdOut !== 5'd9 || writeBackData !== 32'hC0FF_EE00)
            begin n_err++; $display("FAIL stall_next: got %b %0d %h want 1 9 c0ffee00", rwe, rdOut, writeBackData); end
        exp_rd = 5'd9; exp_data = 32'hC0FF_EE00;
    endtask

    task automatic test_errors;
        do_reset();
        do_load(5'd6, 32'h0000_0012, 2'd2, 1'b0, 32'h1111_2222, 2, "lw_misalign");
        do_reset();
        do_load(5'd6, 32'h0000_0010, 2'd3, 1'b0, 32'h3333_4444, 1, "reserved_size");
        do_reset();
        do_load(5'd6, 32'h0000_0013, 2'd1, 1'b1, 32'h5555_6666, 0, "lh_misalign");
        do_reset();
        mem_rsp_valid = 1; mem_rsp_data = 32'hABCD_0123;
        step();
        mem_rsp_valid = 0;
        n_cmp++; if (err !== 1'b1 || rwe !== 1'b0 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL stray_idle: err %b rwe %b ready %b want 1 0 1", err, rwe, in_ready); end
        do_reset();
        in_valid = 1; in_load = 1; in_rd = 5'd8; in_result = 32'h40; in_ldsize = 2'd2;
        mem_rsp_valid = 1; mem_rsp_data = 32'h0BAD_0BAD;
        step();
        in_valid = 0; in_load = 0; mem_rsp_valid = 0;
        n_cmp++; if (err !== 1'b1 || in_ready !== 1'b0)
            begin n_err++; $display("FAIL stray_accept: err %b ready %b want 1 0", err, in_ready); end
        step();
        mem_rsp_valid = 1; mem_rsp_data = 32'h600D_600D;
        step();
        mem_rsp_valid = 0;
        n_cmp++; if (rwe !== 1'b1 || rdOut !== 5'd8 || writeBackData !== 32'h600D_600D)
            begin n_err++; $display("FAIL stray_accept_load: got %b %0d %h want 1 8 600d600d", rwe, rdOut, writeBackData); end
        step();
        do_reset();
        in_valid = 1; in_load = 1; in_rd = 5'd4; in_result = 32'h0; in_ldsize = 2'd2;
        step();
        in_valid = 0; in_load = 0;
        for (int i = 1; i < TO; i++) begin
            step();
            n_cmp++; if (in_ready !== 1'b0 || err !== 1'b0)
                begin n_err++; $display("FAIL timeout_wait[%0d]: ready %b err %b want 0 0", i, in_ready, err); end
        end
        step();
        n_cmp++; if (in_ready !== 1'b1 || err !== 1'b1 || rwe !== 1'b0 || rdOut !== 5'd0)
            begin n_err++; $display("FAIL timeout_end: ready %b err %b rwe %b rd %0d want 1 1 0 0", in_ready, err, rwe, rdOut); end
    endtask

    task automatic test_rd0_and_reset;
        do_reset();
        in_valid = 1; in_load = 0; in_rd = 5'd6; in_result = 32'h1234_5678;
        step();
        in_rd = 5'd0; in_result = 32'hFFFF_FFFF;
        step();
        in_valid = 0;
        n_cmp++; if (rwe !== 1'b0 || rdOut !== 5'd6 || writeBackData !== 32'h1234_5678)
            begin n_err++; $display("FAIL rd0_alu: got %b %0d %h want 0 6 12345678", rwe, rdOut, writeBackData); end
        exp_rd = 5'd6; exp_data = 32'h1234_5678;
        do_load(5'd0, 32'h8, 2'd2, 1'b0, 32'hFEED_FACE, 1, "rd0_load");
        in_valid = 1; in_load = 1; in_rd = 5'd11; in_result = 32'h20; in_ldsize = 2'd2;
        step();
        in_valid = 0; in_load = 0;
        step(); step();
        #2 reset_n = 0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || rdOut !== 5'd0 || err !== 1'b0)
            begin n_err++; $display("FAIL async_reset: ready %b rd %0d err %b want 1 0 0", in_ready, rdOut, err); end
        step();
        reset_n = 1;
        mem_rsp_valid = 1; mem_rsp_data = 32'h7777_7777;
        step();
        mem_rsp_valid = 0;
        n_cmp++; if (rwe !== 1'b0 || err !== 1'b1 || rdOut !== 5'd0)
            begin n_err++; $display("FAIL late_rsp: rwe %b err %b rd %0d want 0 1 0", rwe, err, rdOut); end
        step();
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass;
        do_reset();
        in_valid = 1; in_load = 0; in_rd = 5'd7; in_result = 32'hBEEF_DEED; rsIn = 5'd7; rtIn = 5'd0;
        step();
        in_valid = 0;
        n_cmp++; if (rsFwdHit !== 1'b1 || rsFwd !== 32'hBEEF_DEED || rtFwdHit !== 1'b0 || rtFwd !== 32'd0)
            begin n_err++; $display("FAIL bypass_hit: %b %h %b %h want 1 beefdeed 0 0", rsFwdHit, rsFwd, rtFwdHit, rtFwd); end
        step();
        n_cmp++; if (rsFwdHit !== 1'b0 || rsFwd !== 32'd0)
            begin n_err++; $display("FAIL bypass_idle: %b %h want 0 0", rsFwdHit, rsFwd); end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_alu_random();
        test_loads();
        test_stall();
        test_errors();
        test_rd0_and_reset();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
